// File: rtl/exe_stage_md.sv
// Execute stage: add/sub, address generation with byte-lane store requests,
// and an iterative restoring divider that stalls the pipe while it works.
module exe_stage_md #(
   parameter int XLEN  = 32,
   parameter int NLANE = XLEN / 8
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                flush,
   input  logic                id_to_exe_valid,
   output logic                exe_allowin,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [2:0]          in_op,
   input  logic [XLEN-1:0]     in_src1,
   input  logic [XLEN-1:0]     in_src2,
   input  logic [1:0]          in_size,
   input  logic [XLEN-1:0]     in_store_data,
   input  logic                in_rf_we,
   input  logic [4:0]          in_rf_waddr,
   input  logic                mem_allowin,
   output logic                exe_to_mem_valid,
   output logic [XLEN-1:0]     out_pc,
   output logic [XLEN-1:0]     out_result,
   output logic                out_is_load,
   output logic [1:0]          out_size,
   output logic                out_misalign,
   output logic                out_rf_we,
   output logic [4:0]          out_rf_waddr,
   output logic                data_sram_en,
   output logic [NLANE-1:0]    data_sram_we,
   output logic [XLEN-1:0]     data_sram_addr,
   output logic [XLEN-1:0]     data_sram_wdata,
   output logic                fwd_rf_we,
   output logic [4:0]          fwd_rf_waddr,
   output logic [XLEN-1:0]     fwd_data,
   output logic                fwd_data_ok
);

   localparam int LB = $clog2(NLANE);
   localparam int CW = $clog2(XLEN);

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MOD   = 3'd4;
   localparam logic [2:0] OP_MODU  = 3'd5;
   localparam logic [2:0] OP_LOAD  = 3'd6;
   localparam logic [2:0] OP_STORE = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   logic              exe_valid_q, exe_valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   src1_q, src1_d;
   logic [XLEN-1:0]   src2_q, src2_d;
   logic [1:0]        size_q, size_d;
   logic [XLEN-1:0]   sdata_q, sdata_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_waddr_q, rf_waddr_d;

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [XLEN-1:0]   div_a_q, div_a_d;   // partial remainder
   logic [XLEN-1:0]   div_q_q, div_q_d;   // dividend shifting out, quotient shifting in
   logic [XLEN-1:0]   div_m_q, div_m_d;   // divisor magnitude
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;

   logic              is_div, is_signed, is_load, is_store, is_mem;
   logic              ready_go, misalign;
   logic [XLEN-1:0]   sum, diff, a_abs, b_abs, quo_fix, rem_fix, div_res, result;
   logic [XLEN:0]     shifted, trial;
   logic              ge;
   logic [NLANE-1:0]  lane_mask;
   logic [XLEN-1:0]   wdata_rep;

   assign is_div    = (op_q == OP_DIV) | (op_q == OP_DIVU) | (op_q == OP_MOD) | (op_q == OP_MODU);
   assign is_signed = (op_q == OP_DIV) | (op_q == OP_MOD);
   assign is_load   = (op_q == OP_LOAD);
   assign is_store  = (op_q == OP_STORE);
   assign is_mem    = is_load | is_store;

   assign ready_go         = !is_div | (state_q == S_DONE);
   assign exe_allowin      = !exe_valid_q | (ready_go & mem_allowin);
   assign exe_to_mem_valid = exe_valid_q & ready_go & !flush;

   assign sum  = src1_q + src2_q;
   assign diff = src1_q - src2_q;

   assign a_abs = (is_signed & src1_q[XLEN-1]) ? -src1_q : src1_q;
   assign b_abs = (is_signed & src2_q[XLEN-1]) ? -src2_q : src2_q;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign shifted = {div_a_q, div_q_q[XLEN-1]};
   assign trial   = shifted - {1'b0, div_m_q};
   assign ge      = shifted >= {1'b0, div_m_q};

   assign quo_fix = q_neg_q ? -div_q_q : div_q_q;
   assign rem_fix = r_neg_q ? -div_a_q : div_a_q;
   assign div_res = ((op_q == OP_DIV) | (op_q == OP_DIVU)) ? quo_fix : rem_fix;

   always_comb begin
      case (op_q)
         OP_SUB:                           result = diff;
         OP_DIV, OP_DIVU, OP_MOD, OP_MODU: result = div_res;
         default:                          result = sum;
      endcase
   end

   always_comb begin
      case (size_q)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = sum[0];
         2'd2:    misalign = |sum[1:0];
         default: misalign = (XLEN == 64) ? |sum[2:0] : 1'b1;
      endcase
      misalign = misalign & is_mem;
   end

   always_comb begin
      case (size_q)
         2'd0: begin
            lane_mask = NLANE'(1);
            wdata_rep = {NLANE{sdata_q[7:0]}};
         end
         2'd1: begin
            lane_mask = NLANE'(3);
            wdata_rep = {(NLANE/2){sdata_q[15:0]}};
         end
         2'd2: begin
            lane_mask = NLANE'(4'hF);
            wdata_rep = {(NLANE/4){sdata_q[31:0]}};
         end
         default: begin
            lane_mask = '1;
            wdata_rep = sdata_q;
         end
      endcase
   end

   // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      exe_valid_d = flush ? 1'b0 : (exe_allowin ? id_to_exe_valid : exe_valid_q);
      pc_d        = pc_q;
      op_d        = op_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      size_d      = size_q;
      sdata_d     = sdata_q;
      rf_we_d     = rf_we_q;
      rf_waddr_d  = rf_waddr_q;
      if (id_to_exe_valid & exe_allowin) begin
         pc_d       = in_pc;
         op_d       = in_op;
         src1_d     = in_src1;
         src2_d     = in_src2;
         size_d     = in_size;
         sdata_d    = in_store_data;
         rf_we_d    = in_rf_we;
         rf_waddr_d = in_rf_waddr;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      div_a_d = div_a_q;
      div_q_d = div_q_q;
      div_m_d = div_m_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      if (flush) begin
         state_d = S_IDLE;
         count_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (exe_valid_q & is_div) begin
                  count_d = '0;
                  if (src2_q == '0) begin
                     // Divide by zero: quotient all ones, remainder is the raw dividend.
                     div_q_d = '1;
                     div_a_d = src1_q;
                     q_neg_d = 1'b0;
                     r_neg_d = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     div_q_d = a_abs;
                     div_a_d = '0;
                     div_m_d = b_abs;
                     q_neg_d = is_signed & (src1_q[XLEN-1] ^ src2_q[XLEN-1]);
                     r_neg_d = is_signed & src1_q[XLEN-1];
                     state_d = S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               div_a_d = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
               div_q_d = {div_q_q[XLEN-2:0], ge};
               count_d = count_q + CW'(1);
               if (count_q == CW'(XLEN - 1)) begin
                  count_d = '0;
                  state_d = S_DONE;
               end
            end
            default: begin
               if (!exe_valid_q | mem_allowin) state_d = S_IDLE;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exe_valid_q <= 1'b0;
         pc_q        <= '0;
         op_q        <= OP_ADD;
         src1_q      <= '0;
         src2_q      <= '0;
         size_q      <= '0;
         sdata_q     <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         state_q     <= S_IDLE;
         count_q     <= '0;
         div_a_q     <= '0;
         div_q_q     <= '0;
         div_m_q     <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
      end else begin
         exe_valid_q <= exe_valid_d;
         pc_q        <= pc_d;
         op_q        <= op_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         size_q      <= size_d;
         sdata_q     <= sdata_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         state_q     <= state_d;
         count_q     <= count_d;
         div_a_q     <= div_a_d;
         div_q_q     <= div_q_d;
         div_m_q     <= div_m_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
      end
   end

   assign out_pc       = pc_q;
   assign out_result   = result;
   assign out_is_load  = is_load;
   assign out_size     = size_q;
   assign out_misalign = misalign;
   assign out_rf_we    = rf_we_q & !misalign;
   assign out_rf_waddr = rf_waddr_q;

   assign data_sram_en    = exe_valid_q & is_mem & !misalign & !flush;
   assign data_sram_we    = (is_store & data_sram_en) ? NLANE'(lane_mask << sum[LB-1:0]) : '0;
   assign data_sram_addr  = sum;
   assign data_sram_wdata = wdata_rep;

   assign fwd_rf_we    = exe_valid_q & rf_we_q;
   assign fwd_rf_waddr = rf_waddr_q;
   assign fwd_data     = result;
   assign fwd_data_ok  = exe_valid_q & !is_load & ready_go;

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed-vector bench for exe_stage_md (XLEN=32): ALU, divider latency and
// corner results, store lanes, misalignment, flush and asynchronous reset.
module tb_exe_stage_md;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MOD   = 3'd4;
   localparam logic [2:0] OP_MODU  = 3'd5;
   localparam logic [2:0] OP_LOAD  = 3'd6;
   localparam logic [2:0] OP_STORE = 3'd7;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        id_to_exe_valid;
   logic        exe_allowin;
   logic [31:0] in_pc;
   logic [2:0]  in_op;
   logic [31:0] in_src1, in_src2;
   logic [1:0]  in_size;
   logic [31:0] in_store_data;
   logic        in_rf_we;
   logic [4:0]  in_rf_waddr;
   logic        mem_allowin;
   logic        exe_to_mem_valid;
   logic [31:0] out_pc, out_result;
   logic        out_is_load;
   logic [1:0]  out_size;
   logic        out_misalign, out_rf_we;
   logic [4:0]  out_rf_waddr;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        fwd_rf_we;
   logic [4:0]  fwd_rf_waddr;
   logic [31:0] fwd_data;
   logic        fwd_data_ok;

   int n_vec  = 0;
   int n_miss = 0;

   exe_stage_md #(.XLEN(32)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
      .in_pc(in_pc), .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
      .in_size(in_size), .in_store_data(in_store_data),
      .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
      .mem_allowin(mem_allowin), .exe_to_mem_valid(exe_to_mem_valid),
      .out_pc(out_pc), .out_result(out_result), .out_is_load(out_is_load),
      .out_size(out_size), .out_misalign(out_misalign), .out_rf_we(out_rf_we),
      .out_rf_waddr(out_rf_waddr), .data_sram_en(data_sram_en),
      .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .fwd_rf_we(fwd_rf_we),
      .fwd_rf_waddr(fwd_rf_waddr), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] size, input logic [31:0] sd, input logic we,
                        input logic [4:0] wa);
      id_to_exe_valid = 1'b1;
      in_pc           = 32'h0000_4000 + {26'd0, wa, 1'b0};
      in_op           = op;
      in_src1         = a;
      in_src2         = b;
      in_size         = size;
      in_store_data   = sd;
      in_rf_we        = we;
      in_rf_waddr     = wa;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] size, input logic [31:0] sd, input logic we,
                        input logic [4:0] wa);
      drive(op, a, b, size, sd, we, wa);
      check("allowin_pre_issue", exe_allowin, 1);
      step();
      id_to_exe_valid = 1'b0;
   endtask

   // Counts samples until the divide is handed off; bounded so a stuck divider still reports.
   task automatic wait_go(input string tag, input int exp_lat, input logic [31:0] exp_res);
      int n   = 0;
      int bad = 0;
      while (exe_to_mem_valid !== 1'b1 && n < 100) begin
         if (exe_allowin !== 1'b0 || fwd_data_ok !== 1'b0) bad++;
         step();
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_stall"}, bad, 0);
      check({tag, "_result"}, out_result, exp_res);
      check({tag, "_fwd_ok"}, fwd_data_ok, 1);
   endtask

   task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
      issue(op, a, b, 2'd2, 32'd0, 1'b1, 5'd9);
      wait_go(tag, exp_lat, exp_res);
      step();
      check({tag, "_drained"}, exe_to_mem_valid, 0);
   endtask

   task automatic mem_op(input string tag, input logic [2:0] op, input logic [31:0] base,
                         input logic [31:0] off, input logic [1:0] size, input logic [31:0] sd,
                         input logic exp_en, input logic [3:0] exp_we,
                         input logic [31:0] exp_wdata, input logic exp_mis);
      issue(op, base, off, size, sd, 1'b1, 5'd3);
      check({tag, "_en"}, data_sram_en, exp_en);
      check({tag, "_we"}, data_sram_we, exp_we);
      check({tag, "_addr"}, data_sram_addr, base + off);
      if (exp_en) check({tag, "_wdata"}, data_sram_wdata, exp_wdata);
      check({tag, "_misalign"}, out_misalign, exp_mis);
      check({tag, "_rf_we"}, out_rf_we, !exp_mis);
      step();
   endtask

   initial begin
      int seen;
      resetn = 1'b0; flush = 1'b0; id_to_exe_valid = 1'b0; mem_allowin = 1'b1;
      in_pc = '0; in_op = '0; in_src1 = '0; in_src2 = '0; in_size = '0;
      in_store_data = '0; in_rf_we = 1'b0; in_rf_waddr = '0;

      #23;
      check("rst_allowin", exe_allowin, 1);
      check("rst_to_mem_valid", exe_to_mem_valid, 0);
      check("rst_sram_en", data_sram_en, 0);
      check("rst_fwd_we", fwd_rf_we, 0);
      check("rst_result", out_result, 0);
      @(negedge clk) resetn = 1'b1;
      step();

      // ADD wraps; visible for exactly one cycle
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 2'd2, 32'd0, 1'b1, 5'd5);
      check("add_result", out_result, 32'h0000_0001);
      check("add_valid", exe_to_mem_valid, 1);
      check("add_fwd_ok", fwd_data_ok, 1);
      check("add_fwd_we", fwd_rf_we, 1);
      check("add_fwd_waddr", fwd_rf_waddr, 5);
      check("add_sram_en", data_sram_en, 0);
      step();
      check("add_one_cycle", exe_to_mem_valid, 0);

      issue(OP_SUB, 32'd3, 32'd5, 2'd2, 32'd0, 1'b1, 5'd6);
      check("sub_result", out_result, 32'hFFFF_FFFE);
      step();

      // DIV -7/2 with an ADD waiting behind it
      drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 2'd2, 32'd0, 1'b1, 5'd7);
      step();
      drive(OP_ADD, 32'd10, 32'd20, 2'd2, 32'd0, 1'b1, 5'd8);
      wait_go("div_m7_2", 33, 32'hFFFF_FFFD);
      check("div_handoff_allowin", exe_allowin, 1);
      step();
      id_to_exe_valid = 1'b0;
      check("b2b_add_result", out_result, 32'd30);
      check("b2b_add_waddr", out_rf_waddr, 8);
      check("b2b_add_valid", exe_to_mem_valid, 1);
      step();

      run_div("mod_m7_2", OP_MOD, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
      run_div("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
      run_div("modu_5_0", OP_MODU, 32'd5, 32'd0, 1, 32'd5);
      run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
      run_div("mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
      run_div("divu_big", OP_DIVU, 32'hF000_0000, 32'd3, 33, 32'h5000_0000);
      run_div("mod_7_m2", OP_MOD, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);

      // Store lanes, load, misalignment
      mem_op("st_byte", OP_STORE, 32'h1000, 32'd3, 2'd0, 32'h1234_56AB, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0);
      mem_op("st_half", OP_STORE, 32'h1000, 32'd2, 2'd1, 32'h1234_BEEF, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0);
      mem_op("st_half_mis", OP_STORE, 32'h1000, 32'd1, 2'd1, 32'h1234_BEEF, 1'b0, 4'b0000, 32'd0, 1'b1);
      mem_op("st_word", OP_STORE, 32'h1000, 32'd8, 2'd2, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0);
      mem_op("st_dword32", OP_STORE, 32'h1000, 32'd0, 2'd3, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'd0, 1'b1);
      issue(OP_LOAD, 32'h1000, 32'd4, 2'd2, 32'd0, 1'b1, 5'd4);
      check("ld_en", data_sram_en, 1);
      check("ld_we", data_sram_we, 0);
      check("ld_is_load", out_is_load, 1);
      check("ld_fwd_ok", fwd_data_ok, 0);
      step();

      // MEM back-pressure holds the request stable
      mem_allowin = 1'b0;
      issue(OP_STORE, 32'h2000, 32'd4, 2'd2, 32'h0BAD_CAFE, 1'b0, 5'd0);
      check("stall_allowin", exe_allowin, 0);
      step();
      check("stall_valid", exe_to_mem_valid, 1);
      check("stall_addr", data_sram_addr, 32'h2004);
      check("stall_en", data_sram_en, 1);
      mem_allowin = 1'b1;
      step();
      check("stall_released", exe_to_mem_valid, 0);

      // Flush at BUSY count 10
      issue(OP_DIVU, 32'd100, 32'd7, 2'd2, 32'd0, 1'b1, 5'd10);
      repeat (11) step();
      flush = 1'b1;
      #1;
      check("flush_valid_now", exe_to_mem_valid, 0);
      step();
      flush = 1'b0;
      check("flush_allowin", exe_allowin, 1);
      check("flush_fwd_we", fwd_rf_we, 0);
      seen = 0;
      repeat (40) begin
         if (exe_to_mem_valid === 1'b1) seen++;
         step();
      end
      check("flush_never_valid", seen, 0);
      issue(OP_ADD, 32'd3, 32'd4, 2'd2, 32'd0, 1'b1, 5'd11);
      check("post_flush_add", out_result, 32'd7);
      check("post_flush_valid", exe_to_mem_valid, 1);
      step();
      run_div("post_flush_div", OP_MODU, 32'd100, 32'd7, 33, 32'd2);

      // Asynchronous reset in the middle of a divide
      issue(OP_DIV, 32'd1000, 32'd10, 2'd2, 32'd0, 1'b1, 5'd12);
      repeat (5) step();
      #3 resetn = 1'b0;
      #1;
      check("arst_allowin", exe_allowin, 1);
      check("arst_valid", exe_to_mem_valid, 0);
      check("arst_fwd_we", fwd_rf_we, 0);
      check("arst_fwd_ok", fwd_data_ok, 0);
      check("arst_result", out_result, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      step();
      check("arst_release_allowin", exe_allowin, 1);
      run_div("post_rst_div", OP_DIV, 32'd1000, 32'hFFFF_FFF6, 33, 32'hFFFF_FF9C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
